// File: rtl/snowv_aes_sched.sv
// snowv_aes_sched: runs the two SNOW-V AES round units back to back (R2new = AES(R1), then R3new = AES(R2))
// and shares one S-box word pair between them; a watchdog aborts if a unit never reports ready.
module snowv_aes_sched #(
  parameter int WDOG_MAX = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req,
  input  logic [127:0] r1_i,
  input  logic [127:0] r2_i,
  output logic         ack,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] r2_o,
  output logic [127:0] r3_o,
  output logic         a_start,
  output logic         b_start,
  output logic [127:0] a_block,
  output logic [127:0] b_block,
  input  logic         a_ready,
  input  logic         b_ready,
  input  logic [127:0] a_result,
  input  logic [127:0] b_result,
  input  logic [31:0]  a_sbox_req1,
  input  logic [31:0]  a_sbox_req2,
  input  logic [31:0]  b_sbox_req1,
  input  logic [31:0]  b_sbox_req2,
  output logic [31:0]  sbox_w1_o,
  output logic [31:0]  sbox_w2_o,
  input  logic [31:0]  sbox_w1_i,
  input  logic [31:0]  sbox_w2_i
);
  typedef enum logic [2:0] {IDLE, START_A, WAIT_A, START_B, WAIT_B, DONE} state_t;
  localparam logic [2:0] WD_LIM = 3'(WDOG_MAX);
  state_t       state_q;
  logic [2:0]   wd_q;
  logic [127:0] op_a_q, op_b_q, r2_q, r3_q;
  logic         busy_q, a_start_q, b_start_q, done_q;
  logic         in_wait, unit_ready, expire, owner_b;
  // S-box results are broadcast straight to the units at top level
  logic         unused_sbox;
  assign unused_sbox = ^{sbox_w1_i, sbox_w2_i};
  assign in_wait    = state_q == WAIT_A || state_q == WAIT_B;
  assign unit_ready = state_q == WAIT_A ? a_ready : b_ready;
  assign expire     = in_wait && !unit_ready && wd_q == WD_LIM;
  assign owner_b    = state_q == START_B || state_q == WAIT_B;
  assign ack        = reset_n && req && state_q == IDLE;
  assign err        = reset_n && expire;
  assign busy       = busy_q;
  assign done       = done_q;
  assign a_start    = a_start_q;
  assign b_start    = b_start_q;
  assign a_block    = op_a_q;
  assign b_block    = op_b_q;
  assign r2_o       = r2_q;
  assign r3_o       = r3_q;
  assign sbox_w1_o  = owner_b ? b_sbox_req1 : a_sbox_req1;
  assign sbox_w2_o  = owner_b ? b_sbox_req2 : a_sbox_req2;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wd_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      r2_q      <= '0;
      r3_q      <= '0;
      busy_q    <= 1'b0;
      a_start_q <= 1'b0;
      b_start_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      a_start_q <= 1'b0;
      b_start_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          op_a_q    <= r1_i;
          op_b_q    <= r2_i;
          wd_q      <= '0;
          busy_q    <= 1'b1;
          a_start_q <= 1'b1;
          state_q   <= START_A;
        end
        START_A: state_q <= WAIT_A;
        START_B: state_q <= WAIT_B;
        WAIT_A, WAIT_B: begin
          if (unit_ready) begin
            wd_q <= '0;
            if (state_q == WAIT_A) begin
              r2_q      <= a_result;
              b_start_q <= 1'b1;
              state_q   <= START_B;
            end else begin
              r3_q    <= b_result;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else if (expire) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q + 3'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_snowv_aes_sched.sv
// tb_snowv_aes_sched: behavioural AES round units and S-box pair around the sequencer;
// completions are checked against a queue of expected results.
module tb_snowv_aes_sched;
  logic         clk = 1'b0, reset_n = 1'b0, req = 1'b0, a_hang = 1'b0;
  logic [127:0] r1_i = '0, r2_i = '0;
  logic         ack, busy, done, err, a_start, b_start, a_ready, b_ready;
  logic [127:0] r2_o, r3_o, a_block, b_block, a_result, b_result;
  logic [31:0]  a_sbox_req1, a_sbox_req2, b_sbox_req1, b_sbox_req2;
  logic [31:0]  sbox_w1_o, sbox_w2_o, sbox_w1_i, sbox_w2_i;
  int           cyc = 0, total = 0, bad = 0;
  typedef struct { bit is_err; logic [127:0] r2, r3; int at; } exp_t;
  exp_t         sb[$];
  logic [127:0] m_r2 = '0, m_r3 = '0;

  snowv_aes_sched #(.WDOG_MAX(7)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .r1_i(r1_i), .r2_i(r2_i),
    .ack(ack), .busy(busy), .done(done), .err(err), .r2_o(r2_o), .r3_o(r3_o),
    .a_start(a_start), .b_start(b_start), .a_block(a_block), .b_block(b_block),
    .a_ready(a_ready), .b_ready(b_ready), .a_result(a_result), .b_result(b_result),
    .a_sbox_req1(a_sbox_req1), .a_sbox_req2(a_sbox_req2),
    .b_sbox_req1(b_sbox_req1), .b_sbox_req2(b_sbox_req2),
    .sbox_w1_o(sbox_w1_o), .sbox_w2_o(sbox_w2_o),
    .sbox_w1_i(sbox_w1_i), .sbox_w2_i(sbox_w2_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // inverse as a^254, then the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = sbox(s[127 - 8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_shift(input logic [127:0] s);
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int b = 0; b < 16; b++) t[b] = s[127 - 8*(4*((b/4 + b%4) % 4) + b%4) -: 8];
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 8] = gmul(t[4*c], 8'd2) ^ gmul(t[4*c+1], 8'd3) ^ t[4*c+2] ^ t[4*c+3];
      o[119 - 32*c -: 8] = t[4*c] ^ gmul(t[4*c+1], 8'd2) ^ gmul(t[4*c+2], 8'd3) ^ t[4*c+3];
      o[111 - 32*c -: 8] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'd2) ^ gmul(t[4*c+3], 8'd3);
      o[103 - 32*c -: 8] = gmul(t[4*c], 8'd3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'd2);
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] x);
    return mix_shift(sub_bytes(x));
  endfunction

  assign sbox_w1_i = sub_word(sbox_w1_o);
  assign sbox_w2_i = sub_word(sbox_w2_o);

  // round units: start at t, S-box at t+1/t+2, MixColumns at t+3, ready with result at t+4
  logic [2:0]   u_cnt [2];
  logic [127:0] u_blk [2], u_sb [2], u_res [2];
  logic [1:0]   u_start;
  assign u_start = {b_start, a_start};
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!reset_n) u_cnt[u] <= 3'd0;
      else if (u_cnt[u] == 3'd0) begin
        if (u_start[u]) begin
          u_cnt[u] <= 3'd1;
          u_blk[u] <= (u == 1) ? b_block : a_block;
        end
      end else u_cnt[u] <= (u_cnt[u] == 3'd4) ? 3'd0 : u_cnt[u] + 3'd1;
      if (u_cnt[u] == 3'd1) u_sb[u][127:64] <= {sbox_w1_i, sbox_w2_i};
      if (u_cnt[u] == 3'd2) u_sb[u][63:0] <= {sbox_w1_i, sbox_w2_i};
      if (u_cnt[u] == 3'd3) u_res[u] <= mix_shift(u_sb[u]);
    end
  end
  assign a_sbox_req1 = u_cnt[0] == 3'd1 ? u_blk[0][127:96] : u_cnt[0] == 3'd2 ? u_blk[0][63:32] : 32'h1111_1111;
  assign a_sbox_req2 = u_cnt[0] == 3'd1 ? u_blk[0][95:64]  : u_cnt[0] == 3'd2 ? u_blk[0][31:0]  : 32'h2222_2222;
  assign b_sbox_req1 = u_cnt[1] == 3'd1 ? u_blk[1][127:96] : u_cnt[1] == 3'd2 ? u_blk[1][63:32] : 32'h3333_3333;
  assign b_sbox_req2 = u_cnt[1] == 3'd1 ? u_blk[1][95:64]  : u_cnt[1] == 3'd2 ? u_blk[1][31:0]  : 32'h4444_4444;
  assign a_ready  = !a_hang && (u_cnt[0] == 3'd0 || u_cnt[0] == 3'd4);
  assign b_ready  = u_cnt[1] == 3'd0 || u_cnt[1] == 3'd4;
  assign a_result = u_res[0];
  assign b_result = u_res[1];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, act, want);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    chk(name, {127'b0, act}, {127'b0, want});
  endtask

  always @(negedge clk) begin
    if (done === 1'b1 || err === 1'b1) begin
      if (sb.size() == 0) chk("spurious done/err", {126'b0, done, err}, '0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk1("completion kind err", err, e.is_err);
        chk("completion cycle", 128'(cyc), 128'(e.at));
        chk("r2_o", r2_o, e.r2);
        chk("r3_o", r3_o, e.r3);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic update(input logic [127:0] r1, input logic [127:0] r2, input bit hold);
    req = 1'b1;
    r1_i = r1;
    r2_i = r2;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin
        req = hold;
        r1_i = ~r1;
        r2_i = r1 ^ r2 ^ 128'h5a;
      end
      @(negedge clk);
      chk1("ack", ack, k == 0);
      if (k == 0) begin
        m_r2 = aes_round(r1);
        m_r3 = aes_round(r2);
        sb.push_back('{is_err: 1'b0, r2: m_r2, r3: m_r3, at: cyc + 11});
      end
      chk("sbox owner", {64'b0, sbox_w1_o, sbox_w2_o},
          (k >= 6 && k <= 10) ? {64'b0, b_sbox_req1, b_sbox_req2} : {64'b0, a_sbox_req1, a_sbox_req2});
      if (k == 2) chk("sbox words A hi", {64'b0, sbox_w1_o, sbox_w2_o}, {64'b0, r1[127:64]});
      if (k == 3) chk("sbox words A lo", {64'b0, sbox_w1_o, sbox_w2_o}, {64'b0, r1[63:0]});
      if (k == 7) chk("sbox words B hi", {64'b0, sbox_w1_o, sbox_w2_o}, {64'b0, r2[127:64]});
      if (k == 8) chk("sbox words B lo", {64'b0, sbox_w1_o, sbox_w2_o}, {64'b0, r2[63:0]});
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    req = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk1("reset ack", ack, 1'b0);
      chk1("reset busy", busy, 1'b0);
      chk1("reset done", done, 1'b0);
      chk1("reset err", err, 1'b0);
      chk1("reset a_start", a_start, 1'b0);
      chk("reset r2_o", r2_o, '0);
      chk("reset r3_o", r3_o, '0);
      step();
    end
    reset_n = 1'b1;
    update('0, '0, 1'b0);
    @(negedge clk);
    chk("zero block r2_o", r2_o, {16{8'h63}});
    chk("zero block r3_o", r3_o, {16{8'h63}});
    step();
    update(128'h000102030405060708090a0b0c0d0e0f, '1, 1'b0);
    update(128'h0123456789abcdeffedcba9876543210, 128'hdeadbeef00112233cafef00d44556677, 1'b1);
    update(128'h3243f6a8885a308d313198a2e0370734, 128'h00000000000000000000000000000001, 1'b0);
    a_hang = 1'b1;
    req = 1'b1;
    r1_i = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;
    r2_i = 128'h0f0e0d0c0b0a09080706050403020100;
    for (int k = 0; k < 11; k++) begin
      if (k == 1) req = 1'b0;
      @(negedge clk);
      chk1("hang ack", ack, k == 0);
      if (k == 0) sb.push_back('{is_err: 1'b1, r2: m_r2, r3: m_r3, at: cyc + 9});
      chk1("hang b_start", b_start, 1'b0);
      if (k == 10) begin
        chk1("hang idle", busy, 1'b0);
        chk("hang r2_o held", r2_o, m_r2);
        chk("hang r3_o held", r3_o, m_r3);
      end
      step();
    end
    a_hang = 1'b0;
    update(128'hffeeddccbbaa99887766554433221100, 128'h8899aabbccddeeff0011223344556677, 1'b0);
    req = 1'b1;
    r1_i = 128'h13579bdf2468ace013579bdf2468ace0;
    r2_i = 128'hfedcba98765432100123456789abcdef;
    for (int k = 0; k < 14; k++) begin
      if (k == 1) req = 1'b0;
      if (k == 7) reset_n = 1'b0;
      if (k == 8) reset_n = 1'b1;
      @(negedge clk);
      if (k == 0) chk1("abort ack", ack, 1'b1);
      if (k == 6) chk("abort r2_o captured", r2_o, aes_round(128'h13579bdf2468ace013579bdf2468ace0));
      if (k == 8) begin
        chk1("abort idle", busy, 1'b0);
        chk("abort r2_o", r2_o, '0);
        chk("abort r3_o", r3_o, '0);
      end
      if (k >= 8) chk1("abort no done", done, 1'b0);
      step();
    end
    m_r2 = '0;
    m_r3 = '0;
    update(128'h00112233445566778899aabbccddeeff, 128'h0, 1'b0);
    repeat (3) step();
    @(negedge clk);
    chk("scoreboard drained", 128'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snowv_aes_sched.md
# snowv_aes_sched

Sequencer and S-box arbiter for the two AES encryption round units in the SNOW-V FSM update (R2new = AES(R1), R3new = AES(R2)). The block latches both operands on request and starts round unit A, then round unit B. It multiplexes one shared pair of 32-bit S-box word lookups between them, captures both results and signals completion. It sits between the SNOW-V core FSM and the two round instances.

## Interface
- WDOG_MAX, 7: wait-state cycle limit before a round unit is declared hung.
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- req  in  1  update request from core FSM.
- r1_i  in  128  R1 operand, sampled on accept.
- r2_i  in  128  R2 operand, sampled on accept.
- ack  out  1  combinational: req accepted this cycle.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; r2_o/r3_o valid from this cycle.
- err  out  1  one-cycle pulse on watchdog expiry.
- r2_o  out  128  AES(R1) result register.
- r3_o  out  128  AES(R2) result register.
- a_start / b_start  out  1  start pulse to unit A / B.
- a_block / b_block  out  128  operand to unit A (latched R1) / B (latched R2).
- a_ready / b_ready  in  1  unit ready.
- a_result / b_result  in  128  unit block output.
- a_sbox_req1, a_sbox_req2, b_sbox_req1, b_sbox_req2  in  32  unit S-box word requests.
- sbox_w1_o, sbox_w2_o  out  32  muxed words to the shared S-box pair.
- sbox_w1_i, sbox_w2_i  in  32  S-box results, broadcast to both units at top level.

## Operation
- States: IDLE, START_A, WAIT_A, START_B, WAIT_B, DONE.
- IDLE: ack = req. On req, latch r1_i→opA and r2_i→opB, clear the watchdog, and go to START_A. The accept cycle is counted as cycle 0.
- START_A: a_start=1 for exactly one cycle, then WAIT_A. a_ready is ignored in START_A because the unit still shows ready in the start cycle.
- WAIT_A: increment the watchdog each cycle.
  - On a_ready=1: capture a_result→r2_o, clear the watchdog, go to START_B.
  - If the watchdog equals WDOG_MAX without a_ready: err pulse, go to IDLE, r2_o/r3_o unchanged.
- START_B / WAIT_B: identical to START_A / WAIT_A for unit B. On b_ready, capture b_result→r3_o and go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- S-box owner: B in START_B and WAIT_B; A in all other states.
  - sbox_w1_o/sbox_w2_o = owner's req1/req2.
  - Non-owner requests are dropped.
  - Units are serialized, so they are never in S-box phase simultaneously.
- req while busy: ignored, ack=0. No queueing; the requester must hold req until ack.
- Round keys are not driven by this block; they are tied at top level (SNOW-V uses zero keys).

## Timing
- Reset (reset_n=0 at a clk edge) gives:
  - state IDLE, watchdog 0;
  - r2_o = r3_o = 0, opA = opB = 0;
  - done = err = a_start = b_start = 0, busy = 0;
  - ack follows req combinationally, so it is 0 while reset_n=0 (gated).
- Reset mid-operation aborts immediately: no done or err. The round units share reset_n at top level.
- Nominal unit behaviour: start seen at t; ready low t+1..t+3 (S-box at t+1, t+2, MIXCOL at t+3); ready and result at t+4.
- Nominal schedule:
  - cycle 0: accept;
  - cycle 1: START_A;
  - cycles 2–5: WAIT_A, a_ready seen at cycle 5;
  - cycle 6: START_B;
  - cycles 7–10: WAIT_B;
  - cycle 11: DONE, done=1, results valid;
  - cycle 12: IDLE, a new accept is possible.
- Accept-to-done latency is 11 cycles; back-to-back throughput is one update per 12 cycles.
- r2_o holds from cycle 6 onward; r3_o updates at cycle 11. Both hold until the next successful capture.
- Watchdog: 3-bit counter. Expiry fires in the wait cycle where count == WDOG_MAX; err is asserted in that cycle and the state is IDLE in the next cycle.

## Test plan
- Reset: assert reset_n=0 for 2 cycles with req=1. Required: ack=0, busy=0, r2_o=r3_o=0, done=err=0; first ack appears in the first cycle after release.
- Single update with R1=R2=0, using real round units and S-boxes:
  - done at cycle 11;
  - r2_o = r3_o = AES round of the zero block with zero key = 0x63636363636363636363636363636363.
  - Check S-box owner = A at cycles 2–3 and B at cycles 7–8.
- Distinct operands: R1=0x000102…0f, R2=0xffff…ff. Required: r2_o/r3_o match a golden model; B's S-box words never appear on sbox_w*_o during cycles 0–5.
- req held during busy: req=1 from cycle 0 to cycle 12. Required: ack only at cycles 0 and 12; operands changed mid-run do not affect results.
- Hung unit A: stub with a_ready stuck 0. Required: err pulse at cycle 9 (watchdog reaches 7), IDLE at cycle 10, b_start never asserted, r2_o/r3_o unchanged.
- Reset at cycle 7 (during WAIT_B). Required: next cycle IDLE, done never pulses, r2_o=0.
